// File: rtl/ram_pkg.sv
// Shared widths and the store-buffer entry layout used by the buffer and its lookup.
package ram_pkg;

    localparam int RAM_AW   = 5;
    localparam int RAM_DW   = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic              valid;
        logic [RAM_AW-1:0] dir;
        logic [RAM_DW-1:0] dato;
    } sb_entry_t;

endpackage

// File: rtl/ram_store_buffer_if.sv
// Bundles the store-accept, RAM-drain and load-lookup signals of the store buffer.
interface ram_store_buffer_if
    import ram_pkg::*;
#(
    parameter int DW = RAM_DW,
    parameter int AW = RAM_AW,
    parameter int CW = $clog2(SB_DEPTH) + 1
);

    logic          InValid;
    logic          InReady;
    logic          InWE;
    logic [AW-1:0] InDir;
    logic [DW-1:0] InDato;
    logic [DW-1:0] DatoE;
    logic [AW-1:0] DirRam;
    logic          WE;
    logic          RamReady;
    logic [AW-1:0] LookupDir;
    logic          LookupHit;
    logic [DW-1:0] LookupDato;
    logic [CW-1:0] Ocupacion;

    modport slave (
        input  InValid, InWE, InDir, InDato, RamReady, LookupDir,
        output InReady, DatoE, DirRam, WE, LookupHit, LookupDato, Ocupacion
    );

    modport master (
        output InValid, InWE, InDir, InDato, RamReady, LookupDir,
        input  InReady, DatoE, DirRam, WE, LookupHit, LookupDato, Ocupacion
    );

endinterface

// File: rtl/store_buffer_lookup.sv
// Youngest-match search over valid buffer entries for a load address.
// Latency: purely combinational.
// Backpressure: none; read-only probe of the entry array.
module store_buffer_lookup
    import ram_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int DW    = RAM_DW,
    parameter int AW    = RAM_AW
) (
    input  sb_entry_t [DEPTH-1:0]         entries_i,
    input  logic [$clog2(DEPTH)-1:0]      tail_i,
    input  logic [AW-1:0]                 dir_i,
    output logic                          hit_o,
    output logic [DW-1:0]                 dato_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest so the entry nearest the tail overrides earlier hits.
    always_comb begin
        hit_o  = 1'b0;
        dato_o = '0;
        idx    = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail_i - PW'(k);
            if (entries_i[idx].valid && (entries_i[idx].dir == dir_i)) begin
                hit_o  = 1'b1;
                dato_o = entries_i[idx].dato;
            end
        end
    end

endmodule

// File: rtl/ram_store_buffer.sv
// Store queue in front of the data RAM with same-address merging and load forwarding.
// Latency: a store accepted at edge N is presented to the RAM from edge N+1 at the earliest.
// Backpressure: InReady drops only when full; RamReady stalls the drain, never the accept path.
module ram_store_buffer
    import ram_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int DW    = RAM_DW,
    parameter int AW    = RAM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_store_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic          not_empty;
    logic          in_ready;
    logic          push_req;
    logic          pop;
    logic          merge;
    logic          alloc;
    logic [PW-1:0] youngest;
    logic [DW-1:0] head_dato;
    logic [AW-1:0] head_dir;

    always_comb begin
        not_empty = (count_q != '0);
        in_ready  = (count_q != FULL_CNT);
        youngest  = tail_q - PW'(1);
        pop       = not_empty && bus.RamReady;
        push_req  = bus.InValid && in_ready && bus.InWE;
        // With a single entry the youngest is also the head; if it leaves this cycle, allocate fresh.
        merge     = push_req && not_empty
                    && (entries_q[youngest].dir == bus.InDir)
                    && !(pop && (count_q == CW'(1)));
        alloc     = push_req && !merge;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PW'(1);
        end
        if (merge) begin
            entries_d[youngest].dato = bus.InDato;
        end
        if (alloc) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].dir   = bus.InDir;
            entries_d[tail_q].dato  = bus.InDato;
            tail_d                  = tail_q + PW'(1);
        end

        case ({alloc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign head_dato = not_empty ? entries_q[head_q].dato : '0;
    assign head_dir  = not_empty ? entries_q[head_q].dir  : '0;

    assign bus.InReady   = in_ready;
    assign bus.WE        = not_empty;
    assign bus.DatoE     = head_dato;
    assign bus.DirRam    = head_dir;
    assign bus.Ocupacion = count_q;

    store_buffer_lookup #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_lookup (
        .entries_i (entries_q),
        .tail_i    (tail_q),
        .dir_i     (bus.LookupDir),
        .hit_o     (bus.LookupHit),
        .dato_o    (bus.LookupDato)
    );

endmodule

// File: tb/tb_ram_store_buffer.sv
// Randomized and directed bench for ram_store_buffer against a queue-based reference model.
module tb_ram_store_buffer;

    typedef struct {
        logic [4:0]  dir;
        logic [31:0] dato;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    ent_t q[$];

    ram_store_buffer_if bus ();

    ram_store_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compares every output against the queue model, then advances the model by one edge.
    task automatic step(input logic v, input logic w, input logic [4:0] d, input logic [31:0] x,
                        input logic rr, input logic [4:0] ld);
        int          sz;
        logic        exp_hit;
        logic [31:0] exp_ld;
        logic        exp_pop;
        logic        exp_store;
        logic        exp_merge;
        @(negedge clk);
        bus.InValid   = v;
        bus.InWE      = w;
        bus.InDir     = d;
        bus.InDato    = x;
        bus.RamReady  = rr;
        bus.LookupDir = ld;
        #1;
        sz      = q.size();
        exp_hit = 1'b0;
        exp_ld  = '0;
        for (int i = 0; i < sz; i++) begin
            if (q[i].dir == ld) begin
                exp_hit = 1'b1;
                exp_ld  = q[i].dato;
            end
        end
        chk("InReady",    32'(bus.InReady),    32'(sz < 4));
        chk("WE",         32'(bus.WE),         32'(sz > 0));
        chk("DatoE",      bus.DatoE,           (sz > 0) ? q[0].dato : 32'd0);
        chk("DirRam",     32'(bus.DirRam),     (sz > 0) ? 32'(q[0].dir) : 32'd0);
        chk("Ocupacion",  32'(bus.Ocupacion),  32'(sz));
        chk("LookupHit",  32'(bus.LookupHit),  32'(exp_hit));
        chk("LookupDato", bus.LookupDato,      exp_ld);

        exp_pop   = (sz > 0) && rr;
        exp_store = v && (sz < 4) && w;
        exp_merge = exp_store && (sz >= 1) && (q[sz-1].dir == d) && !(exp_pop && sz == 1);
        if (exp_merge) q[sz-1].dato = x;
        if (exp_pop) void'(q.pop_front());
        if (exp_store && !exp_merge) q.push_back('{dir: d, dato: x});
    endtask

    task automatic idle(input logic rr, input logic [4:0] ld);
        step(1'b0, 1'b0, 5'd0, 32'd0, rr, ld);
    endtask

    task automatic push(input logic [4:0] d, input logic [31:0] x);
        step(1'b1, 1'b1, d, x, 1'b0, 5'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) idle(1'b1, 5'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n         = 1'b0;
        bus.InValid   = 1'b1;
        bus.InWE      = 1'b1;
        bus.InDir     = 5'd3;
        bus.InDato    = 32'hDEAD;
        bus.RamReady  = 1'b0;
        bus.LookupDir = 5'd3;

        // Reset held while a store is offered: nothing may be allocated.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_WE",        32'(bus.WE),         32'd0);
            chk("rst_Ocupacion", 32'(bus.Ocupacion),  32'd0);
            chk("rst_InReady",   32'(bus.InReady),    32'd1);
            chk("rst_LookupHit", 32'(bus.LookupHit),  32'd0);
            chk("rst_DatoE",     bus.DatoE,           32'd0);
        end
        @(negedge clk);
        bus.InValid = 1'b0;
        rst_n       = 1'b1;
        q.delete();
        idle(1'b0, 5'd3);

        // Fill to capacity, then drain in order.
        push(5'd3, 32'hA);
        push(5'd4, 32'hB);
        push(5'd5, 32'hC);
        push(5'd6, 32'hD);
        idle(1'b0, 5'd0);
        chk("full_Ocupacion", 32'(bus.Ocupacion), 32'd4);
        chk("full_InReady",   32'(bus.InReady),   32'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 5'd0);
            chk("drain_DirRam", 32'(bus.DirRam), 32'(3 + i));
            chk("drain_DatoE",  bus.DatoE,       32'(10 + i));
        end
        idle(1'b0, 5'd0);
        chk("drain_WE_off", 32'(bus.WE), 32'd0);

        // Back-to-back stores to one address collapse.
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        idle(1'b0, 5'd0);
        chk("merge_Ocupacion", 32'(bus.Ocupacion), 32'd1);
        idle(1'b1, 5'd0);
        chk("merge_DirRam", 32'(bus.DirRam), 32'd7);
        chk("merge_DatoE",  bus.DatoE,       32'h22);
        idle(1'b0, 5'd0);
        chk("merge_WE_off", 32'(bus.WE), 32'd0);

        // Youngest-match forwarding.
        push(5'd2, 32'h5);
        push(5'd9, 32'h6);
        push(5'd2, 32'h7);
        idle(1'b0, 5'd2);
        chk("lk_hit",     32'(bus.LookupHit), 32'd1);
        chk("lk_dato",    bus.LookupDato,     32'h7);
        idle(1'b0, 5'd1);
        chk("lk_miss",    32'(bus.LookupHit), 32'd0);
        chk("lk_missdat", bus.LookupDato,     32'd0);

        // Full buffer with simultaneous drain and offer: refuse the push, pop once.
        push(5'd12, 32'h8);
        step(1'b1, 1'b1, 5'd13, 32'h99, 1'b1, 5'd0);
        chk("fullpop_InReady", 32'(bus.InReady), 32'd0);
        idle(1'b0, 5'd13);
        chk("fullpop_Ocup",    32'(bus.Ocupacion), 32'd3);
        chk("fullpop_ready",   32'(bus.InReady),   32'd1);
        chk("fullpop_nohit",   32'(bus.LookupHit), 32'd0);
        drain();

        // Asynchronous reset mid-operation.
        push(5'd1, 32'h31);
        push(5'd2, 32'h32);
        push(5'd3, 32'h33);
        idle(1'b0, 5'd0);
        chk("pre_arst_Ocup", 32'(bus.Ocupacion), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_Ocup", 32'(bus.Ocupacion), 32'd0);
        chk("arst_WE",   32'(bus.WE),        32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 5'd2);
            chk("post_arst_WE", 32'(bus.WE), 32'd0);
        end

        // Random traffic over a narrow address range to exercise merges and hits.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)),
                 $urandom(),
                 ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 7)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
